wavetable_read_server: RTL and testbench
========================================

Name: wavetable_read_server

Overview:
- Responder side of the oscillator wavetable read interface.
- Accepts one-cycle read requests (readEn + address) from NUM_VOICES oscillators and arbitrates them round-robin onto one pipelined single-port sample memory.
- Returns each sample on a shared data bus with a per-voice one-cycle load strobe that drives the requesting oscillator's Load/sampIn inputs.

Parameters:
- NUM_VOICES, 4, number of oscillator requesters (≥2).
- D_WIDTH, 16, sample data width.
- A_WIDTH, 12, wavetable address width.
- MEM_LAT, 2, memory read latency in cycles from memRdEn to valid memData (≥1).

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- readEn  in  NUM_VOICES  per-voice request strobe, sampled each rising edge.
- addrIn  in  NUM_VOICES*A_WIDTH  per-voice request address; voice v occupies bits [v*A_WIDTH +: A_WIDTH].
- clrOverrun  in  1  clears all overrun flags.
- memRdEn  out  1  memory read strobe.
- memAddr  out  A_WIDTH  memory read address.
- memData  in  D_WIDTH  memory read data, valid MEM_LAT cycles after memRdEn.
- sampOut  out  D_WIDTH  returned sample (shared by all voices).
- load  out  NUM_VOICES  one-hot strobe: sampOut belongs to this voice.
- overrun  out  NUM_VOICES  sticky per-voice flag: a request was overwritten before service.

Behaviour:
- Reset: clears all pending bits, stored addresses, in-flight tags and the round-robin pointer (pointer = 0). Outputs: memRdEn=0, memAddr=0, sampOut=0, load=0, overrun=0.
- Reset mid-operation: in-flight reads are discarded. No load pulse for a request issued before Reset.
- Request capture:
  - readEn[v]=1 at edge t sets pending[v] and stores addrIn slice v.
  - If pending[v] is already set and not granted at t: the address is overwritten with the new one and overrun[v] is set.
- Arbitration:
  - Each cycle, combinationally select the first pending voice searching from pointer upward, wrapping at NUM_VOICES-1 → 0.
  - On a grant to voice g, the next edge registers memRdEn=1 and memAddr=stored addr[g], clears pending[g], and sets pointer = (g+1) mod NUM_VOICES.
  - No pending voice: memRdEn=0 next cycle, memAddr holds its last value, pointer unchanged.
  - At most one grant per cycle; throughput is one read per cycle.
- Simultaneous events:
  - readEn[g] at the same edge voice g is granted: the grant uses the old address, pending[g] stays set with the new address, and overrun is NOT set.
  - Same-edge readEn on many voices: all captured.
- Tag pipeline:
  - A shift register of depth MEM_LAT carries {valid, voice index}. It is loaded with {memRdEn, granted voice} alongside memAddr.
  - When the tag exits with valid=1, sampOut<=memData and load<=onehot(voice) at that edge.
  - Otherwise load<=0 and sampOut holds its value.
- Latency: readEn at edge t → memRdEn high in cycle t+2 (uncontended) → load and sampOut valid in cycle t+2+MEM_LAT. Contention adds one cycle per voice served ahead.
- Overrun flags:
  - clrOverrun=1 clears all flags at the edge.
  - If an overrun event occurs on the same edge as clrOverrun, the set wins.
- Width rules: no arithmetic beyond the index increment; the pointer is $clog2(NUM_VOICES) bits and wraps explicitly for non-power-of-two NUM_VOICES.
- Ordering: returns for any one voice come back in issue order; load is never asserted for more than one voice per cycle.

Test Plan:
- Single request, memory model returns data = addr XOR 16'hA5A5, MEM_LAT=2: readEn=0001, addr0=12'h123 at edge 0 → memRdEn=1, memAddr=12'h123 in cycle 2; load=0001, sampOut=16'hA486 in cycle 4; all other cycles load=0.
- All four voices request at edge 0 with addrs 0x010/0x020/0x030/0x040 → memAddr sequence 0x010, 0x020, 0x030, 0x040 in cycles 2–5; load = 0001, 0010, 0100, 1000 in cycles 4–7; overrun=0.
- Fairness: voices 0 and 1 assert readEn every cycle for 20 cycles → grants strictly alternate 0,1,0,1; neither voice gets two consecutive grants.
- Overrun: all four request at edge 0, then voice 3 requests addr 0x0FF at edge 2 before its grant → voice 3 is served with 0x0FF, overrun=1000. Asserting clrOverrun → overrun=0000 next cycle.
- Same-cycle re-request: voice 0 requests 0x001, then requests 0x002 on its grant edge → two reads (0x001 then 0x002), two load pulses, overrun[0]=0.
- Reset mid-flight: assert Reset one cycle after memRdEn=1 → no load pulse afterwards, sampOut=0, pending cleared. A new request after Reset is served from pointer 0.

Source files
------------

// File: rtl/wavetable_read_server.sv
// rtl/wavetable_read_server.sv - round-robin wavetable read server for NUM_VOICES oscillators
//
// Purpose: captures one-cycle read requests from each oscillator voice and
// arbitrates them round-robin onto a single pipelined sample memory. Each
// sample comes back on a shared bus with a one-hot load strobe naming the voice.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       synchronous active-high reset
//   readEn      per-voice request strobe
//   addrIn      per-voice request address, voice v at [v*A_WIDTH +: A_WIDTH]
//   clrOverrun  clears all overrun flags (a same-edge overrun event wins)
//   memRdEn     memory read strobe
//   memAddr     memory read address
//   memData     memory read data, valid MEM_LAT cycles after memRdEn
//   sampOut     returned sample, shared by all voices
//   load        one-hot strobe naming the voice that owns sampOut
//   overrun     sticky per-voice flag: a request was overwritten before service
module wavetable_read_server #(
  parameter int NUM_VOICES = 4,
  parameter int D_WIDTH    = 16,
  parameter int A_WIDTH    = 12,
  parameter int MEM_LAT    = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_VOICES-1:0]         readEn,
  input  logic [NUM_VOICES*A_WIDTH-1:0] addrIn,
  input  logic                          clrOverrun,
  output logic                          memRdEn,
  output logic [A_WIDTH-1:0]            memAddr,
  input  logic [D_WIDTH-1:0]            memData,
  output logic [D_WIDTH-1:0]            sampOut,
  output logic [NUM_VOICES-1:0]         load,
  output logic [NUM_VOICES-1:0]         overrun
);

  localparam int PTR_W = $clog2(NUM_VOICES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_VOICES - 1);

  // Request holding registers
  logic [NUM_VOICES-1:0] pending_q, pending_d;
  logic [A_WIDTH-1:0]    addr_q [NUM_VOICES];
  logic [A_WIDTH-1:0]    addr_d [NUM_VOICES];
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  // Memory request port
  logic                  rd_en_q, rd_en_d;
  logic [A_WIDTH-1:0]    rd_addr_q, rd_addr_d;

  // Tag pipeline: stage 0 lines up with memAddr, last stage lines up with memData
  logic [MEM_LAT-1:0]    tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]      tag_vid_q [MEM_LAT];
  logic [PTR_W-1:0]      tag_vid_d [MEM_LAT];

  // Return side
  logic [D_WIDTH-1:0]    samp_q, samp_d;
  logic [NUM_VOICES-1:0] load_q, load_d;
  logic [NUM_VOICES-1:0] ovr_q, ovr_d;

  // Arbitration result
  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      scan;

  // Round-robin search starting at the pointer. The scan index wraps
  // explicitly so non-power-of-two voice counts never index past the end.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = ptr_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!grant_vld && pending_q[scan]) begin
        grant_vld = 1'b1;
        grant_idx = scan;
      end
      scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
    end
  end

  always_comb begin
    pending_d = pending_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    rd_en_d   = grant_vld;
    rd_addr_d = rd_addr_q;
    ovr_d     = clrOverrun ? '0 : ovr_q;
    tag_vld_d = '0;
    for (int k = 0; k < MEM_LAT; k++) begin
      tag_vid_d[k] = '0;
    end
    samp_d    = samp_q;
    load_d    = '0;

    if (grant_vld) begin
      pending_d[grant_idx] = 1'b0;
      rd_addr_d            = addr_q[grant_idx];
      ptr_d                = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end

    // New requests are applied after the grant clear, so a voice re-requesting
    // on its own grant edge keeps pending set with the new address. That case
    // is not an overrun because the old request was just served.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (readEn[v]) begin
        if (pending_q[v] && !(grant_vld && grant_idx == PTR_W'(v))) begin
          ovr_d[v] = 1'b1;
        end
        pending_d[v] = 1'b1;
        addr_d[v]    = addrIn[v*A_WIDTH +: A_WIDTH];
      end
    end

    tag_vld_d[0] = grant_vld;
    tag_vid_d[0] = grant_idx;
    for (int k = 1; k < MEM_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_vid_d[k] = tag_vid_q[k-1];
    end

    if (tag_vld_q[MEM_LAT-1]) begin
      samp_d                          = memData;
      load_d[tag_vid_q[MEM_LAT-1]]    = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        addr_q[v] <= '0;
      end
      ptr_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tag_vld_q <= '0;
      for (int k = 0; k < MEM_LAT; k++) begin
        tag_vid_q[k] <= '0;
      end
      samp_q    <= '0;
      load_q    <= '0;
      ovr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      tag_vld_q <= tag_vld_d;
      tag_vid_q <= tag_vid_d;
      samp_q    <= samp_d;
      load_q    <= load_d;
      ovr_q     <= ovr_d;
    end
  end

  assign memRdEn = rd_en_q;
  assign memAddr = rd_addr_q;
  assign sampOut = samp_q;
  assign load    = load_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_wavetable_read_server.sv
// tb/tb_wavetable_read_server.sv - scoreboard testbench for wavetable_read_server
module tb_wavetable_read_server;

  localparam int NV = 4;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int ML = 2;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [NV-1:0]    readEn;
  logic [NV*AW-1:0] addrIn;
  logic             clrOverrun;
  logic             memRdEn;
  logic [AW-1:0]    memAddr;
  logic [DW-1:0]    memData;
  logic [DW-1:0]    sampOut;
  logic [NV-1:0]    load;
  logic [NV-1:0]    overrun;

  wavetable_read_server #(
    .NUM_VOICES(NV), .D_WIDTH(DW), .A_WIDTH(AW), .MEM_LAT(ML)
  ) dut (
    .Clk(Clk), .Reset(Reset), .readEn(readEn), .addrIn(addrIn),
    .clrOverrun(clrOverrun), .memRdEn(memRdEn), .memAddr(memAddr),
    .memData(memData), .sampOut(sampOut), .load(load), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Memory model: data = addr ^ A5A5, presented for sampling at the edge
  // MEM_LAT edges after the one that registered memRdEn/memAddr.
  logic [DW-1:0] mem_q;
  always @(posedge Clk) mem_q <= DW'(memAddr) ^ 16'hA5A5;
  assign memData = mem_q;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues
  logic [AW-1:0] exp_addr [$];
  int            exp_voice [$];
  logic [DW-1:0] exp_data [$];

  task automatic expect_addr(input logic [AW-1:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic expect_read(input int v, input logic [AW-1:0] a);
    exp_addr.push_back(a);
    exp_voice.push_back(v);
    exp_data.push_back(DW'(a) ^ 16'hA5A5);
  endtask

  bit            mon_on = 1'b0;
  int            mon_v;
  logic [DW-1:0] mon_d;

  always @(negedge Clk) begin
    if (mon_on) begin
      if (memRdEn === 1'b1) begin
        if (exp_addr.size() == 0) check("unexpected_read", 32'(memRdEn), 32'(0));
        else check("memAddr", 32'(memAddr), 32'(exp_addr.pop_front()));
      end
      if (|load === 1'b1) begin
        check("load_onehot", 32'($onehot(load)), 32'(1));
        if (exp_voice.size() == 0) begin
          check("unexpected_load", 32'(load), 32'(0));
        end else begin
          mon_v = exp_voice.pop_front();
          mon_d = exp_data.pop_front();
          check("load_voice", 32'(load), 32'(1) << mon_v);
          check("sampOut", 32'(sampOut), 32'(mon_d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int v, input logic [AW-1:0] a);
    readEn[v]            = 1'b1;
    addrIn[v*AW +: AW]   = a;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_addr.size() != 0 || exp_voice.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check(tag, 32'(exp_addr.size() + exp_voice.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset      = 1'b1;
    readEn     = '0;
    addrIn     = '0;
    clrOverrun = 1'b0;
    repeat (2) tick();
    check("rst_memRdEn", 32'(memRdEn), 32'(0));
    check("rst_memAddr", 32'(memAddr), 32'(0));
    check("rst_sampOut", 32'(sampOut), 32'(0));
    check("rst_load", 32'(load), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    Reset  = 1'b0;
    mon_on = 1'b1;

    // Single request: exact latency
    expect_read(0, 12'h123);
    set_req(0, 12'h123);
    tick();                              // edge 0 -> cycle 1
    readEn = '0;
    check("t1_c1_memRdEn", 32'(memRdEn), 32'(0));
    tick();                              // cycle 2
    check("t1_c2_memRdEn", 32'(memRdEn), 32'(1));
    check("t1_c2_memAddr", 32'(memAddr), 32'h123);
    check("t1_c2_load", 32'(load), 32'(0));
    tick();                              // cycle 3
    check("t1_c3_load", 32'(load), 32'(0));
    tick();                              // cycle 4
    check("t1_c4_load", 32'(load), 32'b0001);
    check("t1_c4_sampOut", 32'(sampOut), 32'hA486);
    tick();                              // cycle 5
    check("t1_c5_load", 32'(load), 32'(0));
    drain("t1_drain");

    // All four voices on the same edge
    do_reset();
    for (int v = 0; v < NV; v++) begin
      expect_read(v, AW'((v + 1) * 16));
      set_req(v, AW'((v + 1) * 16));
    end
    tick();
    readEn = '0;
    drain("t2_drain");
    check("t2_overrun", 32'(overrun), 32'(0));

    // Fairness: voices 0 and 1 request every cycle for 20 cycles
    do_reset();
    for (int k = 0; k < 21; k++) expect_read(k % 2, (k % 2) ? 12'h200 : 12'h100);
    set_req(0, 12'h100);
    set_req(1, 12'h200);
    repeat (20) tick();
    readEn = '0;
    drain("t3_drain");
    check("t3_overrun", 32'(overrun), 32'b0011);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    check("t3_overrun_clr", 32'(overrun), 32'(0));

    // Overrun: voice 3 overwritten before its grant
    do_reset();
    expect_read(0, 12'h010);
    expect_read(1, 12'h020);
    expect_read(2, 12'h030);
    expect_read(3, 12'h0FF);
    for (int v = 0; v < NV; v++) set_req(v, AW'((v + 1) * 16));
    tick();                              // edge 0
    readEn = '0;
    tick();                              // edge 1
    set_req(3, 12'h0FF);
    tick();                              // edge 2
    readEn = '0;
    check("t4_overrun_set", 32'(overrun), 32'b1000);
    drain("t4_drain");
    check("t4_overrun_hold", 32'(overrun), 32'b1000);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    check("t4_overrun_clr", 32'(overrun), 32'(0));

    // Re-request on the grant edge
    do_reset();
    expect_read(0, 12'h001);
    expect_read(0, 12'h002);
    set_req(0, 12'h001);
    tick();                              // edge 0
    set_req(0, 12'h002);
    tick();                              // edge 1: grant of 0x001
    readEn = '0;
    drain("t5_drain");
    check("t5_overrun", 32'(overrun), 32'(0));

    // Reset while reads are in flight
    do_reset();
    expect_addr(12'h111);
    expect_addr(12'h222);
    set_req(1, 12'h111);
    set_req(2, 12'h222);
    set_req(3, 12'h333);
    tick();                              // edge 0
    readEn = '0;
    tick();                              // cycle 2
    check("t6_c2_memRdEn", 32'(memRdEn), 32'(1));
    check("t6_c2_memAddr", 32'(memAddr), 32'h111);
    tick();                              // cycle 3
    Reset = 1'b1;
    tick();                              // edge 3 resets
    Reset = 1'b0;
    check("t6_rst_load", 32'(load), 32'(0));
    check("t6_rst_sampOut", 32'(sampOut), 32'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_post_load", 32'(load), 32'(0));
      check("t6_post_memRdEn", 32'(memRdEn), 32'(0));
    end
    check("t6_post_sampOut", 32'(sampOut), 32'(0));
    expect_read(0, 12'h00A);
    expect_read(3, 12'h00B);
    set_req(0, 12'h00A);
    set_req(3, 12'h00B);
    tick();
    readEn = '0;
    drain("t6_drain");

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
